// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch bundle type used by the fetch stage.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INST_W           = 32;
    localparam int          ROM_ADDR_W       = 14;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } fetch_bundle_t;

endpackage

// File: rtl/ifetch_skid.sv
// Single-entry skid register: holds one fetched instruction while decode
// is backpressuring. Pure storage; the parent decides when to fill or drain.
module ifetch_skid
    import cpu_pkg::*;
(
    input  logic          clock,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          capture,
    input  logic          pop,
    input  fetch_bundle_t fill,
    output logic          valid,
    output fetch_bundle_t entry
);

    // Flush beats capture beats pop; the entry payload only changes on capture.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            entry <= fill;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage in front of a 1-cycle-latency ROM. Owns the PC,
// pairs returned ROM words with their PC, and offers them to decode.
//
// Decode handshake: an instruction transfers on a rising edge where
// inst_valid and inst_ready are both 1. While inst_valid=1 and inst_ready=0,
// inst, inst_pc and inst_valid stay stable until the transfer happens, except
// that a redirect withdraws inst_valid and drops the instruction.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = ROM_ADDR_W
) (
    input  logic              clock,
    input  logic              rst_n,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic [31:0]       inst_pc_plus4,
    output logic              misalign_err,
    output logic [31:0]       fetch_count
);

    logic [31:0]   pc_q;
    logic          f1_valid;
    logic [31:0]   f1_pc;
    logic          skid_valid;
    fetch_bundle_t skid_entry;
    fetch_bundle_t f1_bundle;
    logic          stall;
    logic          issue_en;
    logic          skid_capture;
    logic          skid_pop;

    // The in-flight word is parked in the skid when decode refuses it, and
    // no new fetch is launched while either the stall or the skid is active.
    assign stall        = f1_valid & ~skid_valid & ~inst_ready;
    assign issue_en     = rst_n & ~skid_valid & ~stall & ~redirect_valid;
    assign skid_capture = stall & ~redirect_valid;
    assign skid_pop     = skid_valid & inst_ready & ~redirect_valid;

    assign f1_bundle = '{inst: rom_data, pc: f1_pc};

    assign rom_en   = issue_en;
    assign rom_addr = pc_q[ADDR_W+1:2];

    // Output mux: the skid has priority because it holds the older word.
    always_comb begin
        inst_valid = 1'b0;
        inst       = '0;
        inst_pc    = '0;
        if (rst_n) begin
            inst_valid = (skid_valid | f1_valid) & ~redirect_valid;
            if (skid_valid) begin
                inst    = skid_entry.inst;
                inst_pc = skid_entry.pc;
            end else begin
                inst    = f1_bundle.inst;
                inst_pc = f1_bundle.pc;
            end
        end
    end

    assign inst_pc_plus4 = inst_pc + 32'd4;

    // PC, in-flight tracking and sticky misalign flag; redirect overrides issue.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            f1_valid     <= 1'b0;
            f1_pc        <= '0;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & ~32'h3;
            f1_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else if (issue_en) begin
            f1_valid <= 1'b1;
            f1_pc    <= pc_q;
            pc_q     <= pc_q + 32'd4;
        end else begin
            f1_valid <= 1'b0;
        end
    end

    // Count every ROM read launched since reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (issue_en) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    ifetch_skid u_skid (
        .clock   (clock),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .capture (skid_capture),
        .pop     (skid_pop),
        .fill    (f1_bundle),
        .valid   (skid_valid),
        .entry   (skid_entry)
    );

endmodule
